fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the bubble encoding.
REQ-003 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pc_o, output, 32, the current fetch address driven to instruction memory address a.
REQ-006 SHALL have port instr_i, input, 32, the instruction word returned combinationally by instruction memory rd for pc_o.
REQ-007 SHALL have port stall_i, input, 1, meaning downstream decode cannot accept the IF/ID register this cycle.
REQ-008 SHALL have port redirect_i, input, 1, which signals a taken branch or jump from execute.
REQ-009 SHALL have port redirect_pc_i, input, 32, the redirect target.
REQ-010 SHALL have port out_valid_o, output, 1, meaning the IF/ID register holds a real instruction.
REQ-011 SHALL have port out_instr_o, output, 32, the IF/ID instruction word.
REQ-012 SHALL have port out_pc_o, output, 32, the address of out_instr_o.
REQ-013 SHALL have port out_pc4_o, output, 32, equal to out_pc_o+4, the link value for jal/jalr.
REQ-014 SHALL have port misalign_o, output, 1, a sticky flag for a redirect target with nonzero bits [1:0].
REQ-015 SHALL have port fetch_cnt_o, output, 32, the count of instructions accepted into IF/ID.

Function
REQ-016 SHALL drive pc_o directly from the internal PC register, with no combinational path from any input.
REQ-017 SHALL use the following per-edge priority: reset, then redirect_i, then stall_i, then normal advance.
REQ-018 On a normal advance (no redirect_i, no stall_i), SHALL perform all of the following at the same edge:
- PC <= PC+4.
- out_instr_o <= instr_i.
- out_pc_o <= PC.
- out_pc4_o <= PC+4.
- out_valid_o <= 1.
- fetch_cnt_o += 1.
REQ-019 The IF/ID latency SHALL be exactly one cycle, measured from pc_o presentation to the matching out_instr_o.
REQ-020 On stall_i=1 without redirect_i, SHALL hold the PC, all out_* registers and fetch_cnt_o unchanged.
REQ-021 On redirect_i=1, SHALL perform all of the following at the same edge:
- PC <= {redirect_pc_i[31:2],2'b00}.
- out_valid_o <= 0.
- out_instr_o <= NOP_INSTR.
- out_pc_o and out_pc4_o hold their values.
- fetch_cnt_o unchanged.
REQ-022 redirect_i SHALL take effect even when stall_i=1 in the same cycle.
REQ-023 SHALL set misalign_o to 1 when redirect_i=1 and redirect_pc_i[1:0]!=0, and it SHALL remain 1 until reset.
REQ-024 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000 with no error.
REQ-025 fetch_cnt_o SHALL wrap from 32'hFFFF_FFFF to 0 silently.
REQ-026 Consecutive redirect_i cycles SHALL each reload the PC, and out_valid_o SHALL stay 0 throughout.

Reset
REQ-027 Reset SHALL be synchronous and active-high on clk.
REQ-028 At a reset edge, SHALL set:
- PC = RESET_PC.
- out_valid_o = 0.
- out_instr_o = NOP_INSTR.
- out_pc_o = 0.
- out_pc4_o = 0.
- misalign_o = 0.
- fetch_cnt_o = 0.
REQ-029 Reset SHALL override simultaneous redirect_i and stall_i.
REQ-030 The first fetch SHALL occur on the first edge with reset=0.

Structure
REQ-031 The constants XLEN=32, NOP_INSTR and RESET_PC default SHALL reside in shared package riscv_pkg.
REQ-032 The PC register and its next-PC mux SHALL be a sub-module pc_reg (inputs clk, reset, stall, redirect, target; output pc).
REQ-033 The IF/ID register, misalign flag and counter SHALL reside in fetch_stage.

Verification
REQ-034 Reset scenario: reset high 2 cycles -> pc_o=0, out_valid_o=0, out_instr_o=32'h00000013, fetch_cnt_o=0.
REQ-035 Sequential fetch scenario: memory returns 32'h00500113@0, 32'h00C00193@4, 32'hFF718393@8 -> edge1 gives out_instr_o=32'h00500113, out_pc_o=0, out_pc4_o=4, pc_o=4; edge3 gives out_instr_o=32'hFF718393, fetch_cnt_o=3.
REQ-036 Stall scenario: stall_i=1 for 3 cycles at pc_o=8 -> pc_o, out_* and fetch_cnt_o all constant; first edge after release gives out_pc_o=8.
REQ-037 Redirect scenario: redirect_i=1 with redirect_pc_i=32'h34 while stall_i=1 at pc_o=32'h18 -> next pc_o=32'h34, out_valid_o=0, out_instr_o=NOP; following edge gives out_pc_o=32'h34, out_valid_o=1.
REQ-038 Misaligned redirect scenario: redirect_pc_i=32'h36 -> pc_o=32'h34, misalign_o=1, and misalign_o stays 1 over 10 normal cycles until reset.
REQ-039 Wrap-around scenario: redirect to 32'hFFFFFFFC then advance -> pc_o=0, out_pc_o=32'hFFFFFFFC, out_pc4_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 constants, IF/ID record type and address helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] C_NOP_INSTR   = 32'h0000_0013;
    localparam logic [XLEN-1:0] C_RESET_PC    = 32'h0000_0000;
    localparam logic [XLEN-1:0] C_INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(C_INSTR_BYTES - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with redirect > stall > advance next-PC mux.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = C_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (redirect) begin
            w_pc_next = target;
        end else if (!stall) begin
            // Natural 32-bit wrap past 32'hFFFF_FFFC is intended.
            w_pc_next = r_pc + C_INSTR_BYTES;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32 instruction fetch with IF/ID register, misalign flag and
//               accepted-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = C_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] out_instr_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_pc4_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] fetch_cnt_o
);

    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_target;
    logic            w_advance;
    if_id_t          r_ifid;
    logic            r_misalign;
    logic [XLEN-1:0] r_fetch_cnt;

    assign w_target  = word_align(redirect_pc_i);
    assign w_advance = !redirect_i && !stall_i;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall_i),
        .redirect (redirect_i),
        .target   (w_target),
        .pc       (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid      <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc4: '0};
            r_misalign  <= 1'b0;
            r_fetch_cnt <= '0;
        end else if (redirect_i) begin
            // Squash the wrong-path slot but keep its address fields.
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= NOP_INSTR;
            if (is_misaligned(redirect_pc_i[1:0])) begin
                r_misalign <= 1'b1;
            end
        end else if (w_advance) begin
            r_ifid.valid <= 1'b1;
            r_ifid.instr <= instr_i;
            r_ifid.pc    <= w_pc;
            r_ifid.pc4   <= w_pc + C_INSTR_BYTES;
            r_fetch_cnt  <= r_fetch_cnt + 32'd1;
        end
    end

    assign pc_o        = w_pc;
    assign out_valid_o = r_ifid.valid;
    assign out_instr_o = r_ifid.instr;
    assign out_pc_o    = r_ifid.pc;
    assign out_pc4_o   = r_ifid.pc4;
    assign misalign_o  = r_misalign;
    assign fetch_cnt_o = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios plus
//               randomized stimulus against a behavioural pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_pc4_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .out_valid_o   (out_valid_o),
        .out_instr_o   (out_instr_o),
        .out_pc_o      (out_pc_o),
        .out_pc4_o     (out_pc4_o),
        .misalign_o    (misalign_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a small fixed program, pseudo-random words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0050_0113;
            32'h0000_0004: return 32'h00C0_0193;
            32'h0000_0008: return 32'hFF71_8393;
            default:       return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign instr_i = mem_word(pc_o);

    // Behavioural model: what each register must contain after every edge.
    logic [31:0] m_pc, m_instr, m_out_pc, m_out_pc4, m_cnt;
    logic        m_valid, m_mis, m_init;
    initial m_init = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0000_0013;
            m_out_pc = 32'h0; m_out_pc4 = 32'h0; m_mis = 1'b0; m_cnt = 32'h0;
            m_init = 1'b1;
        end else if (redirect_i) begin
            m_pc    = {redirect_pc_i[31:2], 2'b00};
            m_valid = 1'b0;
            m_instr = 32'h0000_0013;
            if (redirect_pc_i[1:0] != 2'b00) m_mis = 1'b1;
        end else if (!stall_i) begin
            m_instr   = mem_word(m_pc);
            m_out_pc  = m_pc;
            m_out_pc4 = m_pc + 32'd4;
            m_pc      = m_pc + 32'd4;
            m_valid   = 1'b1;
            m_cnt     = m_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("model pc_o",        pc_o,               m_pc);
            chk("model out_valid_o", {31'b0, out_valid_o}, {31'b0, m_valid});
            chk("model out_instr_o", out_instr_o,        m_instr);
            chk("model out_pc_o",    out_pc_o,           m_out_pc);
            chk("model out_pc4_o",   out_pc4_o,          m_out_pc4);
            chk("model misalign_o",  {31'b0, misalign_o}, {31'b0, m_mis});
            chk("model fetch_cnt_o", fetch_cnt_o,        m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        // Reset held two cycles, with stall/redirect asserted to show priority.
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
        tick(); tick();
        chk("reset pc_o",        pc_o,        32'h0);
        chk("reset out_valid_o", {31'b0, out_valid_o}, 32'h0);
        chk("reset out_instr_o", out_instr_o, 32'h0000_0013);
        chk("reset fetch_cnt_o", fetch_cnt_o, 32'h0);
        chk("reset misalign_o",  {31'b0, misalign_o}, 32'h0);
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        reset = 1'b0;

        // Sequential fetch.
        tick();
        chk("seq1 out_instr_o", out_instr_o, 32'h0050_0113);
        chk("seq1 out_pc_o",    out_pc_o,    32'h0);
        chk("seq1 out_pc4_o",   out_pc4_o,   32'h4);
        chk("seq1 pc_o",        pc_o,        32'h4);
        tick(); tick();
        chk("seq3 out_instr_o", out_instr_o, 32'hFF71_8393);
        chk("seq3 fetch_cnt_o", fetch_cnt_o, 32'd3);

        // Stall for three cycles at pc_o = 8.
        do_reset();
        tick(); tick();
        chk("stall start pc_o", pc_o, 32'h8);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall pc_o",        pc_o,        32'h8);
            chk("stall out_pc_o",    out_pc_o,    32'h4);
            chk("stall out_instr_o", out_instr_o, 32'h00C0_0193);
            chk("stall fetch_cnt_o", fetch_cnt_o, 32'd2);
        end
        stall_i = 1'b0;
        tick();
        chk("stall release out_pc_o",    out_pc_o,    32'h8);
        chk("stall release out_instr_o", out_instr_o, 32'hFF71_8393);

        // Redirect while stalled at pc_o = 0x18.
        do_reset();
        repeat (6) tick();
        chk("redir start pc_o", pc_o, 32'h18);
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h34;
        tick();
        chk("redir pc_o",        pc_o,        32'h34);
        chk("redir out_valid_o", {31'b0, out_valid_o}, 32'h0);
        chk("redir out_instr_o", out_instr_o, 32'h0000_0013);
        chk("redir out_pc_o hold", out_pc_o,  32'h14);
        chk("redir fetch_cnt_o", fetch_cnt_o, 32'd6);
        stall_i = 1'b0; redirect_i = 1'b0;
        tick();
        chk("redir next out_pc_o",    out_pc_o,  32'h34);
        chk("redir next out_pc4_o",   out_pc4_o, 32'h38);
        chk("redir next out_valid_o", {31'b0, out_valid_o}, 32'h1);

        // Misaligned redirect: flag is sticky until reset.
        redirect_i = 1'b1; redirect_pc_i = 32'h36;
        tick();
        redirect_i = 1'b0;
        chk("misal pc_o",       pc_o, 32'h34);
        chk("misal misalign_o", {31'b0, misalign_o}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("misal sticky", {31'b0, misalign_o}, 32'h1);
        end
        do_reset();
        chk("misal cleared", {31'b0, misalign_o}, 32'h0);

        // Back-to-back redirects keep the slot invalid.
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        redirect_pc_i = 32'h200;
        tick();
        chk("dbl redir pc_o",        pc_o, 32'h200);
        chk("dbl redir out_valid_o", {31'b0, out_valid_o}, 32'h0);

        // PC wrap-around.
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        tick();
        chk("wrap pc_o",      pc_o,      32'h0);
        chk("wrap out_pc_o",  out_pc_o,  32'hFFFF_FFFC);
        chk("wrap out_pc4_o", out_pc4_o, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            stall_i       = ($urandom_range(0, 9) < 3);
            redirect_i    = ($urandom_range(0, 9) == 0);
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? $urandom()
                                                        : ($urandom() & 32'hFFFF_FFFC);
            tick();
        end
        reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
